mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter.
// Picks one of two requesters, registers its command onto a single memory
// port, and returns grant / error / read-valid pulses to the winning port.
//
// Handshake: a port holds req and its attributes steady until it sees gnt.
// On the memory side, mem_valid with the mem_* fields is held constant until
// the cycle in which mem_ready is high; that cycle is the acceptance. Read
// data is taken from mem_rdata exactly one cycle after a read is accepted.
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    output logic        p0_gnt,
    output logic        p0_err,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    output logic        p1_gnt,
    output logic        p1_err,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        win_q;      // port that owns the current transaction
    logic        last_q;     // port granted most recently
    logic        rej_q;      // current transaction is a rejected (illegal) one
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [1:0]  size_q;

    logic        any_req;
    logic        pick;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        illegal;
    logic        gnt_any, err_any, rvalid_any;

    assign any_req = p0_req | p1_req;

    // Winner selection and alignment check for the request seen in IDLE
    always_comb begin
        pick = 1'b0;
        if (p0_req && p1_req) begin
            pick = FIXED_PRIO ? 1'b0 : ~last_q;
        end else begin
            pick = ~p0_req;
        end
        sel_addr  = pick ? p1_addr  : p0_addr;
        sel_wdata = pick ? p1_wdata : p0_wdata;
        sel_we    = pick ? p1_we    : p0_we;
        sel_size  = pick ? p1_size  : p0_size;
        illegal   = (sel_size == 2'b11) ||
                    ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                    ((sel_size == 2'b01) && sel_addr[0]);
    end

    // Next-state logic and per-transaction pulses; reset suppresses all pulses
    always_comb begin
        state_d    = state_q;
        gnt_any    = 1'b0;
        err_any    = 1'b0;
        rvalid_any = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (rej_q) begin
                    gnt_any = 1'b1;
                    err_any = 1'b1;
                    state_d = IDLE;
                end else if (mem_ready) begin
                    gnt_any = 1'b1;
                    state_d = we_q ? IDLE : RDWAIT;
                end
            end
            RDWAIT: begin
                rvalid_any = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            gnt_any    = 1'b0;
            err_any    = 1'b0;
            rvalid_any = 1'b0;
        end
    end

    // State, command registers and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            rej_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                win_q <= pick;
                rej_q <= illegal;
                if (!illegal) begin
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    we_q    <= sel_we;
                    size_q  <= sel_size;
                end
            end
            if (gnt_any) last_q <= win_q;
        end
    end

    assign mem_valid = (state_q == ISSUE) && !rej_q;
    assign mem_we    = we_q & mem_valid;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

    assign p0_gnt    = gnt_any    & ~win_q;
    assign p1_gnt    = gnt_any    &  win_q;
    assign p0_err    = err_any    & ~win_q;
    assign p1_err    = err_any    &  win_q;
    assign p0_rvalid = rvalid_any & ~win_q;
    assign p1_rvalid = rvalid_any &  win_q;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, hand-written conflict,
// reset-mid-read and fixed-priority sequences, scoreboard on port events.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p1_req = 0;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic        p0_we = 0, p1_we = 0;
    logic [1:0]  p0_size = 0, p1_size = 0;
    logic        mem_ready = 0;
    logic [31:0] mem_rdata = 0;

    logic        p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic        mem_valid, mem_we, busy;
    logic [1:0]  mem_size, fsm_state;

    logic        p0_gnt_f, p1_gnt_f, p0_err_f, p1_err_f, p0_rvalid_f, p1_rvalid_f;
    logic [31:0] p0_rdata_f, p1_rdata_f, mem_addr_f, mem_wdata_f;
    logic        mem_valid_f, mem_we_f, busy_f;
    logic [1:0]  mem_size_f, fsm_state_f;

    // clock / reset
    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_size(p0_size),
        .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_size(p1_size),
        .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .fsm_state(fsm_state)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_size(p0_size),
        .p0_gnt(p0_gnt_f), .p0_err(p0_err_f), .p0_rvalid(p0_rvalid_f), .p0_rdata(p0_rdata_f),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_size(p1_size),
        .p1_gnt(p1_gnt_f), .p1_err(p1_err_f), .p1_rvalid(p1_rvalid_f), .p1_rdata(p1_rdata_f),
        .mem_valid(mem_valid_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_we(mem_we_f),
        .mem_size(mem_size_f), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy_f), .fsm_state(fsm_state_f)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;

    // scoreboard entry: {port, kind, data}; kind 0=write gnt, 1=read gnt, 2=err gnt, 3=rvalid
    localparam int EW = 35;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [EW-1:0] act);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %0h expected none", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL sb_event: got %0h expected %0h", act, e);
            end
        end
    endtask

    // scoreboard monitor on the round-robin instance
    logic        m_port, m_err;
    logic [1:0]  m_kind;
    logic [31:0] m_data;
    always @(negedge clk) begin
        if (mon_en && (p0_gnt | p1_gnt | p0_err | p1_err | p0_rvalid | p1_rvalid)) begin
            check("one_port", {61'd0, p0_gnt & p1_gnt, p0_err & p1_err, p0_rvalid & p1_rvalid}, 64'd0);
            check("err_with_gnt", {63'd0, (p0_err & ~p0_gnt) | (p1_err & ~p1_gnt)}, 64'd0);
            if (p0_gnt || p1_gnt) begin
                m_port = p1_gnt;
                m_err  = m_port ? p1_err : p0_err;
                m_kind = m_err ? 2'd2 : (mem_we ? 2'd0 : 2'd1);
                m_data = m_err ? 32'd0 : mem_addr;
                sb_pop({m_port, m_kind, m_data});
            end
            if (p0_rvalid || p1_rvalid) begin
                m_port = p1_rvalid;
                m_data = m_port ? p1_rdata : p0_rdata;
                sb_pop({m_port, 2'd3, m_data});
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_lat;   // ISSUE cycles before gnt
        int          exp_tail;  // cycles from gnt until busy drops
    } vec_t;

    vec_t vecs[9];

    // driver: reset, leaving the bench just after a posedge with the DUT idle
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_pulses", {58'd0, p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_state", {62'd0, fsm_state}, 64'd0);
        check("rst_mem_fields", {mem_addr, mem_wdata} | {62'd0, mem_size}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive_port(input logic port, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // driver: one lone transaction from idle, checking the issued command
    task automatic run_vec(input vec_t v);
        int got;
        int n;
        drive_port(v.port, v.we, v.size, v.addr, v.wdata);
        mem_rdata = v.rdata;
        mem_ready = (v.stall == 0);
        if (v.exp_err) exp_q.push_back({v.port, 2'd2, 32'd0});
        else if (v.we) exp_q.push_back({v.port, 2'd0, v.addr});
        else begin
            exp_q.push_back({v.port, 2'd1, v.addr});
            exp_q.push_back({v.port, 2'd3, v.rdata});
        end
        got = -1;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            mem_ready = (c >= v.stall);
            @(negedge clk);
            if (v.exp_err) begin
                check("rej_no_valid", {63'd0, mem_valid}, 64'd0);
            end else begin
                check("mem_valid", {63'd0, mem_valid}, 64'd1);
                check("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
                check("mem_fields", {29'd0, mem_we, mem_size, mem_wdata},
                      {29'd0, v.we, v.size, v.wdata});
            end
            if ((v.port ? p1_gnt : p0_gnt) === 1'b1) begin
                got = c;
                p0_req = 1'b0;
                p1_req = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("gnt_latency", 64'(got), 64'(v.exp_lat));
        n = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!busy) begin
                n = c;
                break;
            end
        end
        check("idle_after_gnt", 64'(n), 64'(v.exp_tail));
        p0_req = 1'b0;
        p1_req = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int k, f0, f1, n;
        //          port we  size  addr          wdata         stall rdata         err lat tail
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 0, 2};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 32'h0000_0204, 32'h1122_3344, 3, 32'h0,        1'b0, 3, 1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h0000_0102, 32'h0,        0, 32'h0,         1'b1, 0, 1};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_00FF, 32'h0000_00AB, 0, 32'h0,        1'b0, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_0302, 32'h0,        1, 32'h0000_CAFE, 1'b0, 1, 2};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 32'h0000_0401, 32'h5555_5555, 0, 32'h0,        1'b1, 0, 1};
        vecs[6] = '{1'b0, 1'b1, 2'd3, 32'h0000_0400, 32'h6666_6666, 0, 32'h0,        1'b1, 0, 1};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 32'h0000_07FC, 32'h0,        2, 32'h1234_5678, 1'b0, 2, 2};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 32'h0000_1003, 32'h0,        0, 32'h0000_00A5, 1'b0, 0, 2};

        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // conflict from reset: both write and stay high, grants alternate
        do_reset();
        mem_ready = 1'b1;
        drive_port(1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'hAAAA_0000);
        drive_port(1'b1, 1'b1, 2'd2, 32'h0000_0300, 32'hBBBB_0000);
        for (int j = 0; j < 2; j++) begin
            exp_q.push_back({1'b0, 2'd0, 32'h0000_0200});
            exp_q.push_back({1'b1, 2'd0, 32'h0000_0300});
        end
        k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
                check("rr_gnt_cycle", 64'(c), 64'(1 + 2 * k));
                check("rr_order", {63'd0, p1_gnt}, 64'(k % 2));
                k++;
                if (k == 4) begin
                    p0_req = 1'b0;
                    p1_req = 1'b0;
                    break;
                end
            end
        end
        check("rr_gnt_count", 64'(k), 64'd4);
        @(posedge clk); #1;

        // reset while waiting for read data
        drive_port(1'b0, 1'b0, 2'd2, 32'h0000_0500, 32'h0);
        mem_rdata = 32'h0000_0055;
        exp_q.push_back({1'b0, 2'd1, 32'h0000_0500});
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_rst_gnt", {63'd0, p0_gnt}, 64'd1);
        p0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rd_rst_no_rvalid", {63'd0, p0_rvalid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rd_rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        run_vec('{1'b0, 1'b0, 2'd2, 32'h0000_0600, 32'h0, 0, 32'h7777_8888, 1'b0, 0, 2});
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // fixed priority instance: p1 starves while p0 keeps requesting
        mon_en = 1'b0;
        do_reset();
        mem_ready = 1'b1;
        drive_port(1'b0, 1'b1, 2'd2, 32'h0000_0800, 32'h0);
        drive_port(1'b1, 1'b1, 2'd2, 32'h0000_0900, 32'h0);
        f0 = 0;
        f1 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (p0_gnt_f) f0++;
            if (p1_gnt_f) f1++;
        end
        p0_req = 1'b0;
        check("fp_p1_never", 64'(f1), 64'd0);
        check("fp_p0_count", 64'(f0), 64'd20);
        n = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p1_gnt_f) begin
                n = c;
                break;
            end
        end
        check("fp_p1_after", 64'(n), 64'd2);
        p1_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
